// File: rtl/s27_bist_ctrl.sv
// BIST wrapper for the s27 core: a 4-bit LFSR drives G0..G3 and a 16-bit SISR compacts G17.
// The final signature is compared against a golden value to produce PASS.
module s27_bist_ctrl #(
  parameter logic [7:0]  NPAT      = 8'd15,
  parameter logic [3:0]  SEED      = 4'b0001,
  parameter int unsigned FLUSH_CYC = 3,
  parameter logic [3:0]  FLUSH_PAT = 4'b0000,
  parameter logic [15:0] GOLDEN    = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  output logic        G0,
  output logic        G1,
  output logic        G2,
  output logic        G3,
  input  logic        G17,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIGNATURE,
  output logic [7:0]  PAT_CNT
);

  // An all-zero seed would lock the LFSR, so it is promoted to 0001.
  localparam logic [3:0] SeedEff   = (SEED == 4'b0000) ? 4'b0001 : SEED;
  localparam logic [7:0] FlushLast = 8'(FLUSH_CYC - 1);
  localparam bit         NoFlush   = (FLUSH_CYC == 0);

  typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [3:0]  lfsr_nxt;
  logic        fb;
  logic [15:0] sig_fold;
  logic [7:0]  cnt_inc;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    lfsr_d   = lfsr_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    pass_d   = pass_q;
    lfsr_nxt = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    fb       = sig_q[15] ^ G17;
    sig_fold = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    cnt_inc  = cnt_q + 8'd1;

    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          lfsr_d = SeedEff;
          sig_d  = 16'h0000;
          cnt_d  = 8'd0;
          fcnt_d = 8'd0;
          pass_d = 1'b0;
          if (!NoFlush) begin
            state_d = StFlush;
            pat_d   = FLUSH_PAT;
          end else if (NPAT == 8'd0) begin
            state_d = StDone;
            pat_d   = 4'b0000;
            pass_d  = (GOLDEN == 16'h0000);
          end else begin
            state_d = StRun;
            pat_d   = SeedEff;
          end
        end
      end
      StFlush: begin
        if (fcnt_q == FlushLast) begin
          if (NPAT == 8'd0) begin
            state_d = StDone;
            pat_d   = 4'b0000;
            pass_d  = (sig_q == GOLDEN);
          end else begin
            state_d = StRun;
            pat_d   = lfsr_q;
          end
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      StRun: begin
        // G17 here is the response to the pattern held during this cycle.
        sig_d  = sig_fold;
        lfsr_d = lfsr_nxt;
        pat_d  = lfsr_nxt;
        cnt_d  = cnt_inc;
        if (cnt_inc == NPAT) begin
          state_d = StDone;
          pat_d   = 4'b0000;
          pass_d  = (sig_fold == GOLDEN);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StFlush) || (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      pat_q   <= 4'b0000;
      lfsr_q  <= SeedEff;
      sig_q   <= 16'h0000;
      cnt_q   <= 8'd0;
      fcnt_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {G3, G2, G1, G0} = pat_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIGNATURE = sig_q;
  assign PAT_CNT   = cnt_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed bench for s27_bist_ctrl: five instances cover LFSR order, seed promotion,
// compaction constants, handshake timing, single-bit response error and zero-length test.
module tb_s27_bist_ctrl;

  localparam int unsigned FlushTab [5] = '{3, 3, 3, 3, 0};
  localparam logic [7:0]  NpatTab  [5] = '{8'd16, 8'd16, 8'd1, 8'd2, 8'd0};
  localparam logic [3:0]  SeedTab  [5] = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd1};

  logic ck = 1'b0;
  logic rst;
  logic [4:0] start, g17, g0, g1, g2, g3, busy, done, pass;
  logic [4:0][15:0] sig;
  logic [4:0][7:0]  cnt;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    s27_bist_ctrl #(
      .NPAT(NpatTab[gi]), .SEED(SeedTab[gi]), .FLUSH_CYC(FlushTab[gi]),
      .FLUSH_PAT(4'b0000), .GOLDEN(16'h0000)
    ) u_dut (
      .CK(ck), .RST(rst), .START(start[gi]),
      .G0(g0[gi]), .G1(g1[gi]), .G2(g2[gi]), .G3(g3[gi]), .G17(g17[gi]),
      .BUSY(busy[gi]), .DONE(done[gi]), .PASS(pass[gi]),
      .SIGNATURE(sig[gi]), .PAT_CNT(cnt[gi])
    );
  end

  typedef struct {
    logic        start;
    logic        g17;
    logic [3:0]  pat;
    logic        busy;
    logic        done;
    logic [7:0]  cnt;
    logic [15:0] sig;
  } vec_t;

  function automatic logic [3:0] pat_of(input int i);
    return {g3[i], g2[i], g1[i], g0[i]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [20];
    logic [3:0] seq [16];
    int n;
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    // Cycles 0..2 flush, 3..18 run, 19 done. G17 forced high on run pattern 13 only.
    for (int i = 0; i < 20; i++) begin
      tbl[i].start = 1'b0;
      tbl[i].g17   = 1'b0;
      if (i < 3) begin
        tbl[i].pat = 4'h0; tbl[i].busy = 1'b1; tbl[i].done = 1'b0;
        tbl[i].cnt = 8'd0; tbl[i].sig = 16'h0000;
      end else if (i < 19) begin
        tbl[i].pat = seq[i-3]; tbl[i].busy = 1'b1; tbl[i].done = 1'b0;
        tbl[i].cnt = 8'(i - 3);
        tbl[i].sig = (i == 17) ? 16'h1021 : (i == 18) ? 16'h2042 : 16'h0000;
      end else begin
        tbl[i].pat = 4'h0; tbl[i].busy = 1'b0; tbl[i].done = 1'b1;
        tbl[i].cnt = 8'd16; tbl[i].sig = 16'h4084;
      end
    end
    tbl[1].start  = 1'b1;
    tbl[10].start = 1'b1;
    tbl[16].g17   = 1'b1;

    rst = 1'b1; start = '0; g17 = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_pat", 16'(pat_of(0)), 16'h0);
    chk("reset_sig", sig[0], 16'h0);
    chk("reset_cnt", 16'(cnt[0]), 16'h0);
    chk("reset_flags", {13'd0, busy[0], done[0], pass[0]}, 16'h0);

    // Zero flush, zero patterns: DONE on the cycle after START.
    chk("edge_pre_done", 16'(done[4]), 16'h0);
    start[4] = 1'b1; step(); start[4] = 1'b0;
    chk("edge_flags", {13'd0, busy[4], done[4], pass[4]}, 16'h3);
    chk("edge_sig", sig[4], 16'h0);
    chk("edge_cnt", 16'(cnt[4]), 16'h0);

    g17[2] = 1'b1; g17[3] = 1'b1;
    start[3:0] = 4'hF; step(); start[3:0] = 4'h0;
    for (int i = 0; i < 20; i++) begin
      start[0] = tbl[i].start;
      g17[0]   = tbl[i].g17;
      chk($sformatf("pat_a[%0d]", i), 16'(pat_of(0)), 16'(tbl[i].pat));
      chk($sformatf("pat_b[%0d]", i), 16'(pat_of(1)), 16'(tbl[i].pat));
      chk($sformatf("busy_a[%0d]", i), 16'(busy[0]), 16'(tbl[i].busy));
      chk($sformatf("done_a[%0d]", i), 16'(done[0]), 16'(tbl[i].done));
      chk($sformatf("cnt_a[%0d]", i), 16'(cnt[0]), 16'(tbl[i].cnt));
      chk($sformatf("sig_a[%0d]", i), sig[0], tbl[i].sig);
      step();
    end
    start[0] = 1'b0; g17[0] = 1'b0;
    chk("trojan_sig", sig[0], 16'h4084);
    chk("trojan_pass", 16'(pass[0]), 16'h0);
    chk("trojan_done_hold", 16'(done[0]), 16'h1);
    chk("seed0_sig", sig[1], 16'h0);
    chk("seed0_pass", 16'(pass[1]), 16'h1);
    chk("npat1_sig", sig[2], 16'h1021);
    chk("npat1_cnt", 16'(cnt[2]), 16'h1);
    chk("npat1_pass", 16'(pass[2]), 16'h0);
    chk("npat2_sig", sig[3], 16'h3063);
    chk("npat2_done", 16'(done[3]), 16'h1);

    // Restart from DONE with a clean response.
    start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("restart_sig", sig[0], 16'h0);
    chk("restart_flags", {13'd0, busy[0], done[0], pass[0]}, 16'h4);
    n = 0;
    while (busy[0] && n < 100) begin
      n++;
      step();
    end
    chk("busy_len", 16'(n), 16'd19);
    chk("restart_done", {13'd0, busy[0], done[0], pass[0]}, 16'h3);
    chk("restart_end_sig", sig[0], 16'h0);

    // Reset in the middle of RUN.
    g17[0] = 1'b1;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    repeat (6) step();
    chk("mid_sig", sig[0], 16'h70E7);
    chk("mid_pat", 16'(pat_of(0)), 16'h9);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_pat", 16'(pat_of(0)), 16'h0);
    chk("rst_sig", sig[0], 16'h0);
    chk("rst_cnt", 16'(cnt[0]), 16'h0);
    chk("rst_flags", {13'd0, busy[0], done[0], pass[0]}, 16'h0);
    step();
    chk("rst_stays_idle", {13'd0, busy[0], done[0], pass[0]}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
